// File: rtl/axis_width_downsizer.sv
// AXI-Stream width down-converter: splits each wide input word into R narrow
// output beats from a single holding register, with zero-bubble reload.
module axis_width_downsizer #(
  parameter int unsigned P_IN_WIDTH  = 16,
  parameter int unsigned P_OUT_WIDTH = 8,
  parameter bit          P_MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   S_AXIS_T_VALID,
  output logic                   S_AXIS_T_READY,
  input  logic [P_IN_WIDTH-1:0]  S_AXIS_T_DATA,
  input  logic                   S_AXIS_T_LAST,
  output logic                   M_AXIS_T_VALID,
  input  logic                   M_AXIS_T_READY,
  output logic [P_OUT_WIDTH-1:0] M_AXIS_T_DATA,
  output logic                   M_AXIS_T_LAST,
  output logic                   busy
);

  localparam int unsigned R     = P_IN_WIDTH / P_OUT_WIDTH;
  localparam int unsigned CNT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(R - 1);

  logic                   ready_en_q;
  logic                   hold_valid_q, hold_valid_d;
  logic                   hold_last_q,  hold_last_d;
  logic [P_IN_WIDTH-1:0]  hold_data_q,  hold_data_d;
  logic [CNT_W-1:0]       cnt_q,        cnt_d;
  logic [P_OUT_WIDTH-1:0] m_data_q,     m_data_d;
  logic                   m_last_q,     m_last_d;

  logic in_acc_c;
  logic out_acc_c;
  logic last_slice_c;

  // Slice k of a word, honouring the emission order.
  function automatic logic [P_OUT_WIDTH-1:0] slice_of(input logic [P_IN_WIDTH-1:0] d,
                                                      input logic [CNT_W-1:0]      k);
    int unsigned idx;
    idx = P_MSB_FIRST ? (R - 1 - 32'(k)) : 32'(k);
    return P_OUT_WIDTH'(d >> (idx * P_OUT_WIDTH));
  endfunction

  assign last_slice_c   = (cnt_q == LAST_IDX);
  assign out_acc_c      = hold_valid_q & M_AXIS_T_READY;
  // Combinational from M_AXIS_T_READY so a new word loads as the last slice leaves.
  assign S_AXIS_T_READY = ready_en_q & (~hold_valid_q | (out_acc_c & last_slice_c));
  assign in_acc_c       = S_AXIS_T_VALID & S_AXIS_T_READY;

  assign M_AXIS_T_VALID = hold_valid_q;
  assign M_AXIS_T_DATA  = m_data_q;
  assign M_AXIS_T_LAST  = m_last_q;
  assign busy           = hold_valid_q;

  // Holding register, slice counter and pre-selected output slice.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    hold_data_d  = hold_data_q;
    cnt_d        = cnt_q;

    if (out_acc_c) begin
      if (last_slice_c) begin
        hold_valid_d = 1'b0;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (in_acc_c) begin
      hold_valid_d = 1'b1;
      hold_last_d  = S_AXIS_T_LAST;
      hold_data_d  = S_AXIS_T_DATA;
      cnt_d        = '0;
    end

    m_data_d = slice_of(hold_data_d, cnt_d);
    m_last_d = hold_last_d & (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_data_q  <= '0;
      cnt_q        <= '0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      hold_data_q  <= hold_data_d;
      cnt_q        <= cnt_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
    end
  end

endmodule
